// File: rtl/i2s_frame_tx.sv
// i2s_frame_tx: I2S serializer with a small stereo-frame FIFO.
//
// Parallel stereo frames enter through a valid/ready handshake and are
// buffered in a FIFO. The system clock is divided down to the I2S bit clock.
// Each frame is shifted out MSB-first in standard I2S format, with the MSB
// one bit clock after each LR edge.
//
// Ports:
//   clk         system clock (single clock domain)
//   rst         asynchronous active-high reset
//   in_valid    in_left/in_right hold a frame
//   in_ready    FIFO can accept a frame (registered, depends only on the level)
//   in_left     left sample, two's complement
//   in_right    right sample, two's complement
//   bclk        I2S bit clock, period 2*BCLK_DIV clk cycles
//   lrclk       I2S word select, 0 = left, 1 = right
//   sdata       I2S serial data, changes on the bclk falling edge
//   underrun    one-clk pulse when a frame boundary finds the FIFO empty
//   fifo_level  number of frames currently stored
module i2s_frame_tx #(
  parameter int SAMPLE_W   = 16,
  parameter int BCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [SAMPLE_W-1:0]               in_left,
  input  logic [SAMPLE_W-1:0]               in_right,
  output logic                              bclk,
  output logic                              lrclk,
  output logic                              sdata,
  output logic                              underrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  localparam int FRAME_W = 2 * SAMPLE_W;
  localparam int CNT_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int SLOT_W  = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BCLK_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME_W - 1);
  localparam logic [SLOT_W-1:0] LR_FIRST  = SLOT_W'(SAMPLE_W - 1);
  localparam logic [SLOT_W-1:0] LR_LAST   = SLOT_W'(FRAME_W - 2);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);

  // Word select is raised one slot before the right MSB and dropped one slot
  // before the left MSB, which is what gives the I2S one-bit delay.
  function automatic logic slot_is_right(input logic [SLOT_W-1:0] slot);
    return (slot >= LR_FIRST) && (slot <= LR_LAST);
  endfunction

  // Registered state and next-state values
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic               bclk_q,     bclk_d;
  logic [SLOT_W-1:0]  slot_q,     slot_d;
  logic [FRAME_W-1:0] shift_q,    shift_d;
  logic               sdata_q,    sdata_d;
  logic               lrclk_q,    lrclk_d;
  logic               underrun_q, underrun_d;
  logic [LVL_W-1:0]   level_q,    level_d;
  logic               in_ready_q, in_ready_d;
  logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [FRAME_W-1:0] mem_q [FIFO_DEPTH];

  // Decoded events
  logic               tick_s;
  logic               fall_s;
  logic               wrap_s;
  logic               empty_s;
  logic               push_s;
  logic               pop_s;
  logic [SLOT_W-1:0]  slot_inc_s;
  logic [FRAME_W-1:0] head_s;

  // Next-state logic for the divider, slot counter, shifter and FIFO control
  always_comb begin
    tick_s  = (cnt_q == CNT_LAST);
    fall_s  = tick_s && bclk_q;
    wrap_s  = fall_s && (slot_q == SLOT_LAST);
    // The empty check uses the registered level, so a push on the load clk
    // cannot rescue that load.
    empty_s = (level_q == '0);
    push_s  = in_valid && in_ready_q;
    pop_s   = wrap_s && !empty_s;
    head_s  = mem_q[rd_ptr_q];

    if (tick_s) begin
      cnt_d  = '0;
      bclk_d = ~bclk_q;
    end else begin
      cnt_d  = cnt_q + CNT_W'(1);
      bclk_d = bclk_q;
    end

    if (slot_q == SLOT_LAST) begin
      slot_inc_s = '0;
    end else begin
      slot_inc_s = slot_q + SLOT_W'(1);
    end

    // sdata/lrclk move on the same clk edge as the bclk fall so they are
    // stable for half a bit period before the receiver samples on the rise.
    underrun_d = 1'b0;
    if (fall_s) begin
      slot_d  = slot_inc_s;
      lrclk_d = slot_is_right(slot_inc_s);
      if (wrap_s) begin
        if (empty_s) begin
          shift_d    = '0;
          sdata_d    = 1'b0;
          underrun_d = 1'b1;
        end else begin
          shift_d    = head_s;
          sdata_d    = head_s[FRAME_W-1];
          underrun_d = 1'b0;
        end
      end else begin
        shift_d = {shift_q[FRAME_W-2:0], 1'b0};
        sdata_d = shift_q[FRAME_W-2];
      end
    end else begin
      slot_d  = slot_q;
      lrclk_d = lrclk_q;
      shift_d = shift_q;
      sdata_d = sdata_q;
    end

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    in_ready_d = (level_d < LVL_FULL);

    // Depth is a power of two, so pointers wrap naturally.
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      bclk_q     <= 1'b0;
      slot_q     <= SLOT_LAST;
      shift_q    <= '0;
      sdata_q    <= 1'b0;
      lrclk_q    <= 1'b0;
      underrun_q <= 1'b0;
      level_q    <= '0;
      in_ready_q <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      bclk_q     <= bclk_d;
      slot_q     <= slot_d;
      shift_q    <= shift_d;
      sdata_q    <= sdata_d;
      lrclk_q    <= lrclk_d;
      underrun_q <= underrun_d;
      level_q    <= level_d;
      in_ready_q <= in_ready_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {in_left, in_right};
    end
  end

  assign bclk       = bclk_q;
  assign lrclk      = lrclk_q;
  assign sdata      = sdata_q;
  assign underrun   = underrun_q;
  assign fifo_level = level_q;
  assign in_ready   = in_ready_q;

endmodule

// File: tb/tb_i2s_frame_tx.sv
// Testbench for i2s_frame_tx. The reference model works from elapsed clk
// count since reset release: bclk phase, fall events, slot index and frame
// boundaries are computed arithmetically, and stored frames live in a queue.
module tb_i2s_frame_tx;

  localparam int SW    = 16;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int FRM   = 2 * SW;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [SW-1:0]    in_left = '0;
  logic [SW-1:0]    in_right = '0;
  logic             bclk;
  logic             lrclk;
  logic             sdata;
  logic             underrun;
  logic [LVL_W-1:0] fifo_level;

  i2s_frame_tx #(.SAMPLE_W(SW), .BCLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_left    (in_left),
    .in_right   (in_right),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .sdata      (sdata),
    .underrun   (underrun),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int             k = 0;
  logic [FRM-1:0] mq[$];
  logic [FRM-1:0] cur = '0;
  logic           exp_bclk = 1'b0;
  logic           exp_lr = 1'b0;
  logic           exp_sd = 1'b0;
  logic           exp_un = 1'b0;
  bit             load_now = 1'b0;
  int             fall_slot = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit load_next();
    int kk;
    kk = k + 1;
    return ((kk % (2 * DIV)) == 0) && ((((kk / (2 * DIV)) - 1) % FRM) == 0);
  endfunction

  // Advance the model by one clk edge using the inputs present at that edge.
  task automatic model_edge();
    bit push_e;
    bit empty_e;
    int slot;
    if (rst) begin
      k = 0;
      mq.delete();
      cur = '0;
      exp_bclk = 1'b0;
      exp_lr = 1'b0;
      exp_sd = 1'b0;
      exp_un = 1'b0;
      load_now = 1'b0;
      fall_slot = -1;
    end else begin
      k++;
      push_e = in_valid && (mq.size() < DEPTH);
      empty_e = (mq.size() == 0);
      exp_un = 1'b0;
      load_now = 1'b0;
      fall_slot = -1;
      exp_bclk = (((k / DIV) % 2) == 1);
      if ((k % (2 * DIV)) == 0) begin
        slot = ((k / (2 * DIV)) - 1) % FRM;
        fall_slot = slot;
        if (slot == 0) begin
          load_now = 1'b1;
          if (empty_e) begin
            cur = '0;
            exp_un = 1'b1;
          end else begin
            cur = mq.pop_front();
          end
        end
        exp_sd = cur[FRM-1-slot];
        exp_lr = (slot >= SW - 1) && (slot <= FRM - 2);
      end
      if (push_e) mq.push_back({in_left, in_right});
    end
  endtask

  task automatic check_all();
    check("bclk", 32'(bclk), 32'(exp_bclk));
    check("lrclk", 32'(lrclk), 32'(exp_lr));
    check("sdata", 32'(sdata), 32'(exp_sd));
    check("underrun", 32'(underrun), 32'(exp_un));
    check("fifo_level", 32'(fifo_level), 32'(mq.size()));
    check("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  logic [FRM-1:0] src [5];
  int  idx;
  int  un_cnt;
  bit  found;
  bit  acc;

  initial begin
    // Reset held for 5 clks with in_valid high: nothing may be pushed.
    in_valid = 1'b1;
    in_left = SW'($urandom);
    in_right = SW'($urandom);
    #2 rst = 1'b1;
    repeat (5) step();
    rst = 1'b0;
    in_valid = 1'b0;

    // Single known frame pushed one clk after release.
    step();
    in_valid = 1'b1;
    in_left = 16'hA5F0;
    in_right = 16'h0F0F;
    step();
    in_valid = 1'b0;
    repeat (260) step();

    // Starvation over three frame boundaries.
    un_cnt = 0;
    repeat (768) begin
      step();
      if (underrun) un_cnt++;
    end
    check("starve_pulses", 32'(un_cnt), 32'd3);

    // Full FIFO: align just after a load, then offer five frames back-to-back.
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      step();
      found = load_now;
    end
    check("align_load", 32'(found), 32'd1);
    for (int i = 0; i < 5; i++) src[i] = $urandom;
    idx = 0;
    in_valid = 1'b1;
    {in_left, in_right} = src[0];
    for (int i = 0; i < 5; i++) begin
      acc = in_ready;
      step();
      if (acc && idx < 4) idx++;
      {in_left, in_right} = src[idx];
    end
    check("full_accepted", 32'(idx), 32'd4);
    check("full_level", 32'(fifo_level), 32'd4);
    check("full_ready", 32'(in_ready), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      step();
      found = load_now;
    end
    check("full_wrap", 32'(found), 32'd1);
    check("after_wrap_level", 32'(fifo_level), 32'd3);
    check("after_wrap_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("fifth_level", 32'(fifo_level), 32'd4);

    // Push and pop on the same load clk with two frames stored.
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (mq.size() == 2 && load_next()) found = 1'b1;
      else step();
    end
    check("sim_align", 32'(found), 32'd1);
    in_valid = 1'b1;
    {in_left, in_right} = $urandom;
    step();
    in_valid = 1'b0;
    check("sim_load", 32'(load_now), 32'd1);
    check("sim_level", 32'(fifo_level), 32'd2);
    repeat (800) step();

    // Random traffic.
    repeat (1500) begin
      in_valid = ($urandom_range(0, 99) < 3);
      {in_left, in_right} = $urandom;
      step();
    end
    in_valid = 1'b1;
    {in_left, in_right} = $urandom;
    step();
    in_valid = 1'b0;

    // Asynchronous reset in the middle of slot 20.
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      step();
      found = (fall_slot == 20);
    end
    check("slot20_align", 32'(found), 32'd1);
    step();
    step();
    #1 rst = 1'b1;
    #1;
    check("arst_bclk", 32'(bclk), 32'd0);
    check("arst_lrclk", 32'(lrclk), 32'd0);
    check("arst_sdata", 32'(sdata), 32'd0);
    check("arst_underrun", 32'(underrun), 32'd0);
    check("arst_level", 32'(fifo_level), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd1);
    repeat (3) step();
    rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      found = load_now;
    end
    check("rst_first_load", 32'(found), 32'd1);
    check("rst_first_underrun", 32'(underrun), 32'd1);
    repeat (300) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_frame_tx.md
Name: i2s_frame_tx

Overview:
- Downstream serializer stage for the Pi sample path.
- Accepts parallel stereo sample frames through a valid/ready handshake and buffers them in a small internal FIFO.
- Generates the I2S bit clock and LR clock from the system clock, and shifts samples out MSB-first in standard I2S format (MSB one bit clock after each LR edge).
- Sits between the Pi data receiver and the DAC pins. All logic is in a single clock domain.

Parameters:
- SAMPLE_W, 16: bits per channel sample.
- BCLK_DIV, 4: clk cycles per bclk half-period. Legal range is 1 or more.
- FIFO_DEPTH, 4: stereo frames buffered. Must be a power of two, 2 or more.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  in_left/in_right hold a frame.
- in_ready  out  1  FIFO can accept a frame.
- in_left  in  SAMPLE_W  left sample, two's complement.
- in_right  in  SAMPLE_W  right sample.
- bclk  out  1  I2S bit clock.
- lrclk  out  1  I2S word select; 0 = left, 1 = right.
- sdata  out  1  I2S serial data.
- underrun  out  1  one-clk pulse when a frame boundary finds the FIFO empty.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  frames currently stored.

Behaviour:
- Reset values (rst asserts asynchronously): bclk=0, lrclk=0, sdata=0, underrun=0, fifo_level=0, in_ready=1. FIFO pointers cleared, divider count=0, slot counter s=2*SAMPLE_W-1, shift register=0.
- Divider:
  - cnt runs 0..BCLK_DIV-1. At cnt==BCLK_DIV-1, bclk toggles and cnt returns to 0.
  - bclk period = 2*BCLK_DIV clk cycles.
  - A "fall event" is the clk edge where bclk toggles 1->0.
- Slot counter s (0..2*SAMPLE_W-1):
  - On every fall event, s increments and wraps 2*SAMPLE_W-1 -> 0.
  - sdata and lrclk are registered and update on the same clk edge as the bclk fall.
  - The receiver samples on the bclk rise.
- lrclk = 1 for s in [SAMPLE_W-1, 2*SAMPLE_W-2], 0 otherwise.
  - lrclk therefore changes one slot before the MSB of each channel.
- Frame load: on the fall event where s wraps to 0:
  - FIFO non-empty: pop one frame; shift register = {left,right}; sdata = left MSB.
  - FIFO empty: shift register = 0; underrun pulses high for exactly that clk; output is silence.
- On other fall events the shift register shifts left by one and sdata = the new MSB.
- FIFO:
  - in_ready = (fifo_level < FIFO_DEPTH). A push occurs when in_valid && in_ready.
  - Push only: level+1. Pop only: level-1. Push and pop in the same clk: level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - The empty check at frame load uses the registered level. A push in the same clk as a load from empty is accepted, the load still underruns, and the level becomes 1.
- Latency: a frame pushed into an empty FIFO starts at the next s wrap. Its left MSB appears on sdata on that fall event.
- Reset mid-frame: all state is abandoned immediately. The next frame starts from the reset state, with the first fall event loading slot 0.
- No combinational path from inputs to outputs. in_ready depends only on the registered level.

Test Plan:
- Reset: hold rst 5 clks with in_valid=1 -> bclk=lrclk=sdata=0, fifo_level=0, in_ready=1, no push counted.
- Single frame (SAMPLE_W=16, BCLK_DIV=4): push L=16'hA5F0, R=16'h0F0F one clk after reset release.
  - First bclk fall occurs at clk 8.
  - sdata at successive bclk rises = A5F0 MSB-first, then 0F0F.
  - lrclk is 1 exactly during slots 15..30.
  - underrun stays 0.
- Starvation: no pushes for 3 frames -> underrun pulses once every 256 clks (one clk wide), sdata=0 throughout, lrclk keeps toggling every 16 bclk.
- Full FIFO: push 5 frames back-to-back.
  - Only 4 are accepted; in_ready=0 and fifo_level=4.
  - After the next s wrap: fifo_level=3, in_ready=1.
  - The fifth frame must be re-presented by the source.
- Simultaneous push/pop: with fifo_level=2, assert in_valid on the load clk -> fifo_level stays 2 and the data order is preserved.
- Reset mid-frame: assert rst during slot 20 -> outputs go to reset values in the same clk without waiting for clk. After release, the FIFO is empty and the first load underruns.
